// File: rtl/sync_ram_clr.sv
// sync_ram_clr
// Single-port synchronous RAM with a self-clearing sweep.
// After reset, or on a clr request, every location is overwritten with
// CLR_VAL, one word per cycle. busy is high for the whole sweep and we/re/clr
// are ignored while it is high. Once the sweep ends, the block is a plain
// RAM with a registered read port (latency 1) and a one-cycle q_valid strobe.
//
// Parameters
//   DATA_W   : word width in bits
//   ADDR_W   : address width; depth is 2**ADDR_W words
//   RDW_MODE : same-address read-during-write returns old (0) or new (1) data
//   CLR_VAL  : word written by the clear sweep
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (starts a new sweep on release)
//   clr     : single-cycle request to start a clear sweep
//   we      : write enable
//   re      : read enable
//   addr    : shared read/write address
//   data    : write data
//   q       : registered read data
//   q_valid : one-cycle strobe, q updated by a read on this edge
//   busy    : clear sweep in progress
module sync_ram_clr #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic [DATA_W-1:0] q_r;
    logic              q_valid_r;
    logic              busy_r;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              mem_wr_s;
    logic [ADDR_W-1:0] mem_wa_s;
    logic [DATA_W-1:0] mem_wd_s;
    logic [DATA_W-1:0] rd_data_s;

    // Select the memory write source: the sweep while clearing, the user
    // port in IDLE unless clr pre-empts it. Nothing is written while reset
    // is held, so an aborted sweep leaves memory untouched until release.
    always_comb begin
        mem_wr_s = 1'b0;
        mem_wa_s = addr;
        mem_wd_s = data;
        if (!rst_n) begin
            mem_wr_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_wr_s = 1'b1;
            mem_wa_s = cnt_r;
            mem_wd_s = CLR_VAL;
        end else if (!clr && we) begin
            mem_wr_s = 1'b1;
        end else begin
            mem_wr_s = 1'b0;
        end
    end

    // Read data for a user read; on a same-cycle write, the new word bypasses
    // the array when new-data semantics are selected.
    always_comb begin
        rd_data_s = mem_r[addr];
        if ((RDW_MODE != 0) && we) begin
            rd_data_s = data;
        end else begin
            rd_data_s = mem_r[addr];
        end
    end

    // Storage array; deliberately not reset, the sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    // Sweep/idle controller with registered q, q_valid and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            cnt_r     <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
            busy_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    q_valid_r <= 1'b0;
                    // The last location ends the sweep; cnt never wraps
                    // back to re-clear location 0.
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state_r   <= ST_CLEAR;
                        busy_r    <= 1'b1;
                        cnt_r     <= '0;
                        q_valid_r <= 1'b0;
                    end else if (re) begin
                        q_r       <= rd_data_s;
                        q_valid_r <= 1'b1;
                    end else begin
                        q_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    busy_r    <= 1'b1;
                    cnt_r     <= '0;
                    q_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign q       = q_r;
    assign q_valid = q_valid_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_sync_ram_clr.sv
// Bench for sync_ram_clr: two instances (old-data and new-data
// read-during-write) share one stimulus stream and are compared against a
// plain array model of the RAM contents.
module tb_sync_ram_clr;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] q0, q1;
    logic          qv0, qv1;
    logic          busy0, busy1;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] eq0, eq1;

    always #5 clk = ~clk;

    sync_ram_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .CLR_VAL(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .re(re), .addr(addr),
        .data(data), .q(q0), .q_valid(qv0), .busy(busy0)
    );

    sync_ram_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .CLR_VAL(8'h00)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .re(re), .addr(addr),
        .data(data), .q(q1), .q_valid(qv1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One IDLE cycle with the given we/re; checks both instances afterwards.
    task automatic access(input logic w, input logic r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        clr  = 1'b0;
        we   = w;
        re   = r;
        addr = a;
        data = d;
        if (r) begin
            eq0 = mem_m[a];
            eq1 = w ? d : mem_m[a];
        end
        if (w) mem_m[a] = d;
        step();
        we = 1'b0;
        re = 1'b0;
        chk("q_valid_old", {31'd0, qv0}, {31'd0, r});
        chk("q_valid_new", {31'd0, qv1}, {31'd0, r});
        chk("q_old", {24'd0, q0}, {24'd0, eq0});
        chk("q_new", {24'd0, q1}, {24'd0, eq1});
    endtask

    // Count busy cycles (bounded); optionally hammer the ports meanwhile.
    task automatic wait_sweep(input bit noise);
        int n;
        n = 0;
        while (busy0 && n < 200) begin
            if (noise) begin
                we   = 1'($urandom_range(0, 1));
                re   = 1'($urandom_range(0, 1));
                clr  = 1'($urandom_range(0, 1));
                addr = AW'($urandom);
                data = DW'($urandom);
            end
            n++;
            step();
            if (noise) begin
                chk("busy_q_valid_old", {31'd0, qv0}, 32'd0);
                chk("busy_q_valid_new", {31'd0, qv1}, 32'd0);
                chk("busy_q_hold_old", {24'd0, q0}, {24'd0, eq0});
                chk("busy_q_hold_new", {24'd0, q1}, {24'd0, eq1});
            end
        end
        clr = 1'b0;
        we  = 1'b0;
        re  = 1'b0;
        chk("sweep_len", n, 32'd64);
        chk("busy_new_done", {31'd0, busy1}, 32'd0);
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, AW'(i), 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        addr  = '0;
        data  = '0;
        eq0   = 8'h00;
        eq1   = 8'h00;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;

        // Reset state
        step(); step(); step();
        chk("rst_q", {24'd0, q0}, 32'd0);
        chk("rst_q_valid", {31'd0, qv0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd1);
        rst_n = 1'b1;
        wait_sweep(1'b0);
        read_all();

        // Write then read
        access(1'b1, 1'b0, 6'd5, 8'hA5);
        access(1'b0, 1'b0, 6'd0, 8'h00);
        access(1'b0, 1'b1, 6'd5, 8'h00);
        chk("rd5_val", {24'd0, q0}, 32'hA5);
        chk("rd5_valid", {31'd0, qv0}, 32'd1);
        access(1'b0, 1'b0, 6'd0, 8'h00);
        chk("rd5_valid_drop", {31'd0, qv0}, 32'd0);
        chk("rd5_hold", {24'd0, q0}, 32'hA5);

        // Read during write
        access(1'b1, 1'b0, 6'd9, 8'h11);
        access(1'b1, 1'b1, 6'd9, 8'h22);
        chk("rdw_old", {24'd0, q0}, 32'h11);
        chk("rdw_new", {24'd0, q1}, 32'h22);
        access(1'b0, 1'b1, 6'd9, 8'h00);
        chk("rdw_mem_old", {24'd0, q0}, 32'h22);
        chk("rdw_mem_new", {24'd0, q1}, 32'h22);

        // Random traffic
        for (int i = 0; i < 300; i++)
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 15)), DW'($urandom));

        // Clear request with a competing write, ports hammered during sweep
        for (int i = 0; i < DEPTH; i++) access(1'b1, 1'b0, AW'(i), 8'hFF);
        clr  = 1'b1;
        we   = 1'b1;
        addr = 6'd3;
        data = 8'h77;
        step();
        clr = 1'b0;
        we  = 1'b0;
        chk("clr_busy", {31'd0, busy0}, 32'd1);
        wait_sweep(1'b1);
        read_all();
        access(1'b0, 1'b1, 6'd3, 8'h00);
        chk("clr_addr3", {24'd0, q0}, 32'h00);

        // Reset in the middle of a sweep
        for (int i = 0; i < DEPTH; i++) access(1'b1, 1'b0, AW'(i), DW'($urandom) | 8'h01);
        access(1'b0, 1'b1, 6'd7, 8'h00);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 30; i++) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_q", {24'd0, q0}, 32'd0);
        chk("midrst_busy", {31'd0, busy0}, 32'd1);
        chk("midrst_q_valid", {31'd0, qv0}, 32'd0);
        eq0 = 8'h00;
        eq1 = 8'h00;
        step();
        rst_n = 1'b1;
        wait_sweep(1'b0);
        read_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
